// File: rtl/stack_eval.sv
// RPN operand stack evaluator: pushes operands, applies + - * / on the top two
// entries (division is a multi-cycle restoring divider), and reports on equals.
module stack_eval #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             num_valid,
    input  logic [WIDTH-1:0] num,
    input  logic             op_valid,
    input  logic [3:0]       op,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [4:0]       depth,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [4:0]    SP_FULL  = 5'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;
    localparam logic [3:0] OP_EQ  = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_DIV  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [4:0]       r_sp, w_sp_nxt;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_divisor;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid, r_error, r_ready;
    logic [1:0]       r_err_code, w_err_code_nxt;

    logic [AW-1:0]    w_top_idx, w_sec_idx, w_wr_idx;
    logic [WIDTH-1:0] w_top, w_sec, w_alu, w_wr_data, w_quo_nxt, w_rem_nxt;
    logic [WIDTH:0]   w_rem_sh, w_diff;
    logic             w_wr_en, w_res_load, w_op_load, w_div_init, w_div_step, w_ge;

    assign w_top_idx = AW'(r_sp - 5'd1);
    assign w_sec_idx = AW'(r_sp - 5'd2);
    assign w_top     = r_stack[w_top_idx];
    assign w_sec     = r_stack[w_sec_idx];

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_divisor};
    assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    assign ready        = r_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign depth        = r_sp;
    assign error        = r_error;
    assign err_code     = r_err_code;

    // Single-cycle arithmetic for the EXEC state (a = second, b = top).
    always_comb begin
        w_alu = {WIDTH{1'b0}};
        case (r_op)
            OP_ADD:  w_alu = w_sec + w_top;
            OP_SUB:  w_alu = w_sec - w_top;
            OP_MUL:  w_alu = w_sec * w_top;
            default: w_alu = w_sec;
        endcase
    end

    // Next-state and stack-update decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_sp_nxt       = r_sp;
        w_wr_en        = 1'b0;
        w_wr_idx       = {AW{1'b0}};
        w_wr_data      = {WIDTH{1'b0}};
        w_res_load     = 1'b0;
        w_op_load      = 1'b0;
        w_div_init     = 1'b0;
        w_div_step     = 1'b0;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (num_valid) begin
                    if (r_sp == SP_FULL) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = 2'b01;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = AW'(r_sp);
                        w_wr_data = num;
                        w_sp_nxt  = r_sp + 5'd1;
                    end
                end else if (op_valid) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                            if (r_sp < 5'd2) begin
                                w_state_nxt    = S_ERR;
                                w_err_code_nxt = 2'b10;
                            end else begin
                                w_op_load   = 1'b1;
                                w_state_nxt = (op == OP_DIV) ? S_DIV : S_EXEC;
                            end
                        end
                        OP_EQ: begin
                            if (r_sp == 5'd1) begin
                                w_res_load  = 1'b1;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt    = S_ERR;
                                w_err_code_nxt = 2'b10;
                            end
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                w_wr_en     = 1'b1;
                w_wr_idx    = w_sec_idx;
                w_wr_data   = w_alu;
                w_sp_nxt    = r_sp - 5'd1;
                w_state_nxt = S_IDLE;
            end
            S_DIV: begin
                // Count 0 is the setup cycle; counts 1..WIDTH each produce a quotient bit.
                if (r_cnt == {CW{1'b0}}) begin
                    if (w_top == {WIDTH{1'b0}}) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = 2'b11;
                    end else begin
                        w_div_init = 1'b1;
                    end
                end else begin
                    w_div_step = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = w_sec_idx;
                        w_wr_data   = w_quo_nxt;
                        w_sp_nxt    = r_sp - 5'd1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_DONE: begin
                if (num_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = {AW{1'b0}};
                    w_wr_data   = num;
                    w_sp_nxt    = 5'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stack storage; only the pointer is reset.
    always_ff @(posedge clk) begin
        if (reset_n && w_wr_en) begin
            r_stack[w_wr_idx] <= w_wr_data;
        end
    end

    // Pointer, divider, result and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sp           <= 5'd0;
            r_op           <= 4'h0;
            r_cnt          <= {CW{1'b0}};
            r_rem          <= {WIDTH{1'b0}};
            r_quo          <= {WIDTH{1'b0}};
            r_divisor      <= {WIDTH{1'b0}};
            r_result       <= {WIDTH{1'b0}};
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_err_code     <= 2'b00;
            r_ready        <= 1'b1;
        end else begin
            r_sp           <= w_sp_nxt;
            r_result_valid <= w_res_load;
            r_err_code     <= w_err_code_nxt;
            r_error        <= r_error | (w_state_nxt == S_ERR);
            r_ready        <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
            if (w_res_load) r_result <= w_top;
            if (w_op_load)  r_op     <= op;
            if (r_state != S_DIV) r_cnt <= {CW{1'b0}};
            else                  r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (w_div_init) begin
                r_quo     <= w_sec;
                r_divisor <= w_top;
                r_rem     <= {WIDTH{1'b0}};
            end else if (w_div_step) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
            end
        end
    end
endmodule
